// File: rtl/partition_sweep_checker.sv
// partition_sweep_checker
//   Exhaustive sweep engine for one approximate-logic partition. It drives every
//   input pattern 0..2^NUM_IN-1 in ascending order into the approximate
//   partition and its exact golden twin. After SETTLE cycles it samples both
//   outputs, streams {pattern, po_approx} over a ready/valid port, and
//   accumulates error metrics for on-chip quality evaluation.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start              one-cycle sweep request (honoured in IDLE or DONE only)
//   pi_out             pattern currently driven to both partitions
//   po_approx/po_exact approximate / golden partition outputs
//   cap_valid/ready    capture stream handshake
//   cap_data           {pattern, po_approx} as sampled
//   busy, done         sweep in progress / sweep finished (held until next start)
//   err_count          number of mismatching patterns
//   bit_flips          summed popcount(po_approx ^ po_exact)
//   max_abs_err        largest |po_approx - po_exact| (unsigned)
//   first_err_valid    at least one mismatch seen in this sweep
//   first_err_pattern  lowest mismatching pattern
module partition_sweep_checker #(
    parameter int unsigned NUM_IN  = 7,
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned SETTLE  = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    output logic [NUM_IN-1:0]                        pi_out,
    input  logic [NUM_OUT-1:0]                       po_approx,
    input  logic [NUM_OUT-1:0]                       po_exact,
    output logic                                     cap_valid,
    input  logic                                     cap_ready,
    output logic [NUM_IN+NUM_OUT-1:0]                cap_data,
    output logic                                     busy,
    output logic                                     done,
    output logic [NUM_IN:0]                          err_count,
    output logic [NUM_IN+$clog2(NUM_OUT):0]          bit_flips,
    output logic [NUM_OUT-1:0]                       max_abs_err,
    output logic                                     first_err_valid,
    output logic [NUM_IN-1:0]                        first_err_pattern
);

    localparam int unsigned CAP_W  = NUM_IN + NUM_OUT;
    localparam int unsigned ERR_W  = NUM_IN + 1;
    localparam int unsigned FLIP_W = NUM_IN + $clog2(NUM_OUT) + 1;
    localparam int unsigned CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   settle_cnt, settle_cnt_nxt;
    logic [NUM_IN-1:0]  pattern_nxt;
    logic               cap_valid_nxt;
    logic [CAP_W-1:0]   cap_data_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic [ERR_W-1:0]   err_count_nxt;
    logic [FLIP_W-1:0]  bit_flips_nxt;
    logic [NUM_OUT-1:0] max_abs_err_nxt;
    logic               first_err_valid_nxt;
    logic [NUM_IN-1:0]  first_err_pattern_nxt;

    // Per-pattern comparison of the two partitions
    logic [NUM_OUT-1:0] diff_bits;
    logic               mismatch;
    logic [NUM_OUT-1:0] abs_err;
    logic [FLIP_W-1:0]  flip_inc;

    always_comb begin
        diff_bits = po_approx ^ po_exact;
        mismatch  = |diff_bits;
        abs_err   = (po_approx >= po_exact) ? (po_approx - po_exact)
                                            : (po_exact - po_approx);
        flip_inc  = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            flip_inc = flip_inc + FLIP_W'(diff_bits[i]);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt             = state;
        settle_cnt_nxt        = settle_cnt;
        pattern_nxt           = pi_out;
        cap_valid_nxt         = cap_valid;
        cap_data_nxt          = cap_data;
        busy_nxt              = busy;
        done_nxt              = done;
        err_count_nxt         = err_count;
        bit_flips_nxt         = bit_flips;
        max_abs_err_nxt       = max_abs_err;
        first_err_valid_nxt   = first_err_valid;
        first_err_pattern_nxt = first_err_pattern;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_count_nxt         = '0;
                    bit_flips_nxt         = '0;
                    max_abs_err_nxt       = '0;
                    first_err_valid_nxt   = 1'b0;
                    first_err_pattern_nxt = '0;
                    done_nxt              = 1'b0;
                    busy_nxt              = 1'b1;
                    pattern_nxt           = '0;
                    settle_cnt_nxt        = CNT_W'(SETTLE - 1);
                    state_nxt             = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = ST_SAMPLE;
                end else begin
                    settle_cnt_nxt = settle_cnt - CNT_W'(1);
                end
            end

            ST_SAMPLE: begin
                if (mismatch) begin
                    err_count_nxt = err_count + ERR_W'(1);
                    bit_flips_nxt = bit_flips + flip_inc;
                    if (abs_err > max_abs_err) begin
                        max_abs_err_nxt = abs_err;
                    end
                    // Ascending sweep order makes the first hit the lowest pattern
                    if (!first_err_valid) begin
                        first_err_valid_nxt   = 1'b1;
                        first_err_pattern_nxt = pi_out;
                    end
                end
                cap_data_nxt  = {pi_out, po_approx};
                cap_valid_nxt = 1'b1;
                state_nxt     = ST_EMIT;
            end

            ST_EMIT: begin
                if (cap_ready) begin
                    cap_valid_nxt = 1'b0;
                    // Terminal pattern ends the sweep instead of wrapping
                    if (&pi_out) begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        pattern_nxt    = pi_out + NUM_IN'(1);
                        settle_cnt_nxt = CNT_W'(SETTLE - 1);
                        state_nxt      = ST_SETTLE;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt        <= '0;
            pi_out            <= '0;
            cap_valid         <= 1'b0;
            cap_data          <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err_count         <= '0;
            bit_flips         <= '0;
            max_abs_err       <= '0;
            first_err_valid   <= 1'b0;
            first_err_pattern <= '0;
        end else begin
            settle_cnt        <= settle_cnt_nxt;
            pi_out            <= pattern_nxt;
            cap_valid         <= cap_valid_nxt;
            cap_data          <= cap_data_nxt;
            busy              <= busy_nxt;
            done              <= done_nxt;
            err_count         <= err_count_nxt;
            bit_flips         <= bit_flips_nxt;
            max_abs_err       <= max_abs_err_nxt;
            first_err_valid   <= first_err_valid_nxt;
            first_err_pattern <= first_err_pattern_nxt;
        end
    end

endmodule

// File: tb/tb_partition_sweep_checker.sv
// Bench for partition_sweep_checker: default instance (7 in / 4 out / settle 1)
// driven through several directed sweeps, plus a 5 in / 3 out / settle 3 instance.
`timescale 1ns/1ps
module tb_partition_sweep_checker;

    localparam int unsigned NI  = 7;
    localparam int unsigned NO  = 4;
    localparam int unsigned ST  = 1;
    localparam int unsigned NIB = 5;
    localparam int unsigned NOB = 3;
    localparam int unsigned STB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst = 1'b1;
    int   mode_a = 0;

    // Default instance
    logic                  start_a = 1'b0;
    logic [NI-1:0]         pi_out_a;
    logic [NO-1:0]         po_approx_a, po_exact_a;
    logic                  cap_valid_a;
    logic                  cap_ready_a = 1'b1;
    logic [NI+NO-1:0]      cap_data_a;
    logic                  busy_a, done_a;
    logic [NI:0]           err_count_a;
    logic [NI+$clog2(NO):0] bit_flips_a;
    logic [NO-1:0]         max_abs_err_a;
    logic                  first_err_valid_a;
    logic [NI-1:0]         first_err_pattern_a;

    // Small instance
    logic                   start_b = 1'b0;
    logic [NIB-1:0]         pi_out_b;
    logic [NOB-1:0]         po_approx_b, po_exact_b;
    logic                   cap_valid_b;
    logic                   cap_ready_b = 1'b1;
    logic [NIB+NOB-1:0]     cap_data_b;
    logic                   busy_b, done_b;
    logic [NIB:0]           err_count_b;
    logic [NIB+$clog2(NOB):0] bit_flips_b;
    logic [NOB-1:0]         max_abs_err_b;
    logic                   first_err_valid_b;
    logic [NIB-1:0]         first_err_pattern_b;

    // Partition behaviours: 0 identical, 1 approx drops bit 0, 2 approx = ~exact (3 bits)
    function automatic int exact_f(input int mode, input int p);
        if (mode == 2) return p & 7;
        return p & 15;
    endfunction

    function automatic int approx_f(input int mode, input int p);
        case (mode)
            0:       return p & 15;
            1:       return p & 14;
            default: return (~p) & 7;
        endcase
    endfunction

    assign po_exact_a  = NO'(exact_f(mode_a, int'(pi_out_a)));
    assign po_approx_a = NO'(approx_f(mode_a, int'(pi_out_a)));
    assign po_exact_b  = NOB'(exact_f(2, int'(pi_out_b)));
    assign po_approx_b = NOB'(approx_f(2, int'(pi_out_b)));

    partition_sweep_checker #(.NUM_IN(NI), .NUM_OUT(NO), .SETTLE(ST)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .pi_out(pi_out_a),
        .po_approx(po_approx_a), .po_exact(po_exact_a),
        .cap_valid(cap_valid_a), .cap_ready(cap_ready_a), .cap_data(cap_data_a),
        .busy(busy_a), .done(done_a), .err_count(err_count_a), .bit_flips(bit_flips_a),
        .max_abs_err(max_abs_err_a), .first_err_valid(first_err_valid_a),
        .first_err_pattern(first_err_pattern_a)
    );

    partition_sweep_checker #(.NUM_IN(NIB), .NUM_OUT(NOB), .SETTLE(STB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pi_out(pi_out_b),
        .po_approx(po_approx_b), .po_exact(po_exact_b),
        .cap_valid(cap_valid_b), .cap_ready(cap_ready_b), .cap_data(cap_data_b),
        .busy(busy_b), .done(done_b), .err_count(err_count_b), .bit_flips(bit_flips_b),
        .max_abs_err(max_abs_err_b), .first_err_valid(first_err_valid_b),
        .first_err_pattern(first_err_pattern_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference metrics computed directly over the whole pattern space
    task automatic model(input int mode, input int n, output int errs, output int flips,
                         output int maxe, output int fv, output int fp);
        errs = 0; flips = 0; maxe = 0; fv = 0; fp = 0;
        for (int p = 0; p < n; p++) begin
            int a, e, d;
            a = approx_f(mode, p);
            e = exact_f(mode, p);
            if (a != e) begin
                errs++;
                flips += $countones(a ^ e);
                d = (a > e) ? a - e : e - a;
                if (d > maxe) maxe = d;
                if (fv == 0) begin fv = 1; fp = p; end
            end
        end
    endtask

    // Capture-stream scoreboard state for the default instance
    int             exp_pat   = 0;
    int             cap_cnt   = 0;
    bit             prev_stall = 1'b0;
    logic [NI+NO-1:0] prev_data = '0;

    // Per-cycle compare, called once per negedge after inputs are settled
    task automatic observe();
        longint exp_word;
        if (rst) begin
            exp_pat = 0; cap_cnt = 0; prev_stall = 1'b0;
            return;
        end
        if (start_a && !busy_a) begin
            exp_pat = 0; cap_cnt = 0;
        end
        if (prev_stall) begin
            check("cap_valid_held", longint'(cap_valid_a), 1);
            check("cap_data_held", longint'(cap_data_a), longint'(prev_data));
        end
        if (cap_valid_a) begin
            check("pi_out_during_emit", longint'(pi_out_a), longint'(exp_pat));
        end
        if (cap_valid_a && cap_ready_a) begin
            exp_word = (longint'(exp_pat) << NO) | longint'(approx_f(mode_a, exp_pat));
            check("cap_word", longint'(cap_data_a), exp_word);
            exp_pat++;
            cap_cnt++;
        end
        prev_stall = cap_valid_a && !cap_ready_a;
        prev_data  = cap_data_a;
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_pi_out"}, longint'(pi_out_a), 0);
        check({tag, "_cap_valid"}, longint'(cap_valid_a), 0);
        check({tag, "_cap_data"}, longint'(cap_data_a), 0);
        check({tag, "_busy"}, longint'(busy_a), 0);
        check({tag, "_done"}, longint'(done_a), 0);
        check({tag, "_err_count"}, longint'(err_count_a), 0);
        check({tag, "_bit_flips"}, longint'(bit_flips_a), 0);
        check({tag, "_max_abs_err"}, longint'(max_abs_err_a), 0);
        check({tag, "_first_err_valid"}, longint'(first_err_valid_a), 0);
        check({tag, "_first_err_pattern"}, longint'(first_err_pattern_a), 0);
    endtask

    // One sweep of the default instance with optional stall / restart / reset events
    task automatic run_a(input int mode, input int stall_pat, input int restart_pat,
                         input int reset_pat, output int cycles);
        int  s;
        int  stall_cnt;
        bit  restarted;
        bit  finished;
        mode_a = mode;
        stall_cnt = 0; restarted = 1'b0; finished = 1'b0; cycles = -1;
        @(negedge clk);
        start_a = 1'b1;
        observe();
        @(negedge clk);
        start_a = 1'b0;
        s = cyc;
        check("busy_after_start", longint'(busy_a), 1);
        check("done_cleared", longint'(done_a), 0);
        observe();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (done_a) begin
                finished = 1'b1;
                cycles = cyc - s;
                break;
            end
            if (reset_pat >= 0 && int'(pi_out_a) == reset_pat) begin
                rst = 1'b1;
                observe();
                @(negedge clk);
                rst = 1'b0;
                check_zero_a("mid_reset");
                return;
            end
            if (restart_pat >= 0 && !restarted && int'(pi_out_a) == restart_pat) begin
                start_a   = 1'b1;
                restarted = 1'b1;
            end
            if (stall_pat >= 0 && cap_valid_a && int'(pi_out_a) == stall_pat && stall_cnt < 5) begin
                cap_ready_a = 1'b0;
                stall_cnt++;
            end else begin
                cap_ready_a = 1'b1;
            end
            observe();
        end
        cap_ready_a = 1'b1;
        check("sweep_finished", longint'(finished), 1);
        check("capture_count", longint'(cap_cnt), 128);
        check("busy_at_done", longint'(busy_a), 0);
    endtask

    task automatic check_metrics_a(input string tag, input int mode);
        int errs, flips, maxe, fv, fp;
        model(mode, 1 << NI, errs, flips, maxe, fv, fp);
        check({tag, "_err_count"}, longint'(err_count_a), errs);
        check({tag, "_bit_flips"}, longint'(bit_flips_a), flips);
        check({tag, "_max_abs_err"}, longint'(max_abs_err_a), maxe);
        check({tag, "_first_err_valid"}, longint'(first_err_valid_a), fv);
        check({tag, "_first_err_pattern"}, longint'(first_err_pattern_a), fp);
    endtask

    initial begin
        int cycles;
        int ref_err;
        repeat (3) @(negedge clk);
        check_zero_a("reset");
        check("reset_b_pi_out", longint'(pi_out_b), 0);
        check("reset_b_done", longint'(done_b), 0);
        rst = 1'b0;

        // Identical partitions: clean sweep
        run_a(0, -1, -1, -1, cycles);
        check("t1_cycles", cycles, 384);
        check_metrics_a("t1", 0);
        check("t1_err_lit", longint'(err_count_a), 0);
        check("t1_done", longint'(done_a), 1);

        // Approx drops LSB: every odd pattern mismatches by exactly 1
        run_a(1, -1, -1, -1, cycles);
        check("t2_cycles", cycles, 384);
        check_metrics_a("t2", 1);
        check("t2_err_lit", longint'(err_count_a), 64);
        check("t2_flips_lit", longint'(bit_flips_a), 64);
        check("t2_max_lit", longint'(max_abs_err_a), 1);
        check("t2_first_lit", longint'(first_err_pattern_a), 1);
        ref_err = int'(err_count_a);
        repeat (4) begin
            @(negedge clk);
            observe();
        end
        check("t2_done_held", longint'(done_a), 1);
        check("t2_err_held", longint'(err_count_a), 64);

        // Backpressure for 5 cycles on pattern 10
        run_a(1, 10, -1, -1, cycles);
        check("t3_cycles", cycles, 389);
        check_metrics_a("t3", 1);

        // Reset at pattern 50, then a clean sweep
        run_a(1, -1, -1, 50, cycles);
        run_a(1, -1, -1, -1, cycles);
        check("t4_cycles", cycles, 384);
        check_metrics_a("t4", 1);

        // Start re-pulsed at pattern 20 is ignored
        run_a(1, -1, 20, -1, cycles);
        check("t5_cycles", cycles, 384);
        check("t5_err_vs_undisturbed", longint'(err_count_a), ref_err);
        check_metrics_a("t5", 1);

        // Small instance: approx = ~exact, 3 outputs, settle 3
        begin
            int s, nb, errs, flips, maxe, fv, fp;
            bit fin;
            nb = 0; fin = 1'b0;
            @(negedge clk);
            start_b = 1'b1;
            @(negedge clk);
            start_b = 1'b0;
            s = cyc;
            for (int k = 0; k < 1000; k++) begin
                if (cap_valid_b && cap_ready_b) begin
                    check("b_cap_word", longint'(cap_data_b),
                          (longint'(nb) << NOB) | longint'(approx_f(2, nb)));
                    nb++;
                end
                @(negedge clk);
                if (done_b) begin
                    fin = 1'b1;
                    check("b_cycles", cyc - s, 160);
                    break;
                end
            end
            check("b_finished", longint'(fin), 1);
            check("b_capture_count", nb, 32);
            model(2, 1 << NIB, errs, flips, maxe, fv, fp);
            check("b_err_count", longint'(err_count_b), errs);
            check("b_bit_flips", longint'(bit_flips_b), flips);
            check("b_max_abs_err", longint'(max_abs_err_b), maxe);
            check("b_first_err_valid", longint'(first_err_valid_b), fv);
            check("b_first_err_pattern", longint'(first_err_pattern_b), fp);
            check("b_err_lit", longint'(err_count_b), 32);
            check("b_flips_lit", longint'(bit_flips_b), 96);
            check("b_max_lit", longint'(max_abs_err_b), 7);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
